// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encoding
// and the default address/data widths, reset address and halt opcode.
package fetch_pkg;

  localparam int unsigned  AW_DEF         = 16;
  localparam int unsigned  DW_DEF         = 16;
  localparam logic [15:0]  RESET_ADDR_DEF = 16'h0000;
  localparam logic [15:0]  HALT_WORD_DEF  = 16'hFFFF;

  // S_HALT is only reachable when the halt feature is built in.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program-counter register for the fetch sequencer.
// Update priority: reset > load > increment. Arithmetic wraps modulo 2^AW.
module fetch_pc import fetch_pkg::*; #(
  parameter int unsigned      AW         = AW_DEF,
  parameter logic [AW-1:0]    RESET_ADDR = AW'(RESET_ADDR_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q
);

  logic [AW-1:0] pc_q;

  // PC register: synchronous reset, then jump load, then sequential increment.
  // NOTE: clocked state is always written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_ADDR;
    end else if (load) begin
      pc_q <= d;
    end else if (inc) begin
      pc_q <= pc_q + AW'(1);
    end
  end

  assign q = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. Issues single reads to a 1-cycle-latency
// synchronous memory, presents each word to decode over valid/ready, and
// accepts jump redirects in any state.
// Optional feature: define FETCH_HALT_EN to stop fetching after HALT_WORD has
// been delivered (halted=1 until redirect or reset). Without it, HALT_WORD is an
// ordinary instruction and halted is constant 0.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int unsigned   AW         = AW_DEF,
  parameter int unsigned   DW         = DW_DEF,
  parameter logic [AW-1:0] RESET_ADDR = AW'(RESET_ADDR_DEF),
  parameter logic [DW-1:0] HALT_WORD  = DW'(HALT_WORD_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_addr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  output logic          halted
);

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] ipc_q, ipc_d;
  logic          halted_q, halted_d;
  logic          halt_pend_q, halt_pend_d;  // held word is the halt opcode

  logic [AW-1:0] pc;
  logic          pc_load;
  logic          pc_inc;
  logic          halt_hit;

  fetch_pc #(
    .AW         (AW),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .inc   (pc_inc),
    .d     (redir_addr),
    .q     (pc)
  );

  // The memory interface is combinational from state, PC and run.
  assign mem_addr  = pc;
  assign mem_rd_en = (state_q == S_ISSUE) && run;

  assign halt_hit  = HALT_EN && (mem_rd_data == HALT_WORD);

  // Next-state and output-register logic; a redirect overrides every state.
  // NOTE: every signal assigned here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    data_d      = data_q;
    ipc_d       = ipc_q;
    halted_d    = halted_q;
    halt_pend_d = halt_pend_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    if (redir_valid) begin
      // Any in-flight or held word is abandoned; an accept in the same HOLD
      // cycle has already completed on the consumer side, so the result is
      // identical either way.
      pc_load     = 1'b1;
      valid_d     = 1'b0;
      halted_d    = 1'b0;
      halt_pend_d = 1'b0;
      state_d     = S_ISSUE;
    end else begin
      unique case (state_q)
        S_ISSUE: begin
          if (run) state_d = S_WAIT;
        end
        S_WAIT: begin
          valid_d     = 1'b1;
          data_d      = mem_rd_data;
          ipc_d       = pc;
          pc_inc      = 1'b1;
          halt_pend_d = halt_hit;
          state_d     = S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            valid_d     = 1'b0;
            halt_pend_d = 1'b0;
            if (halt_pend_q) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              state_d  = S_ISSUE;
            end
          end
        end
        S_HALT: begin
          // Parked until redirect or reset.
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end

  // State and registered outputs; reset discards any outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ISSUE;
      valid_q     <= 1'b0;
      data_q      <= '0;
      ipc_q       <= '0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      ipc_q       <= ipc_d;
      halted_q    <= halted_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr_data  = data_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;

endmodule
